// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One op in flight: IDLE (grant/accept) -> EXEC (drive ALU, capture) -> RESP (hold until accepted).
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][3:0]           req_control,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_left,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_right,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [WIDTH-1:0]                  resp_result,
    output logic                              resp_zero,
    output logic [3:0]                        alu_control,
    output logic [WIDTH-1:0]                  alu_left_operand,
    output logic [WIDTH-1:0]                  alu_right_operand,
    input  logic [WIDTH-1:0]                  alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, next_state;
    logic               last_grant;
    logic               owner;
    logic               win;
    logic               any_valid;
    logic               accept;
    logic [3:0]         op_control;
    logic [WIDTH-1:0]   op_left;
    logic [WIDTH-1:0]   op_right;

    // Combinational grant: a lone requester wins; on a tie the one not served last wins.
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win       = 1'b0;
        any_valid = 1'b0;
        case (req_valid)
            2'b01: begin win = 1'b0;        any_valid = 1'b1; end
            2'b10: begin win = 1'b1;        any_valid = 1'b1; end
            2'b11: begin win = ~last_grant; any_valid = 1'b1; end
            default: ;
        endcase
    end

    assign accept    = (state == IDLE) && !flush && !reset && any_valid;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;

    assign alu_control       = op_control;
    assign alu_left_operand  = op_left;
    assign alu_right_operand = op_right;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = EXEC;
            EXEC: next_state = flush ? IDLE : RESP;
            RESP: if (flush || resp_ready[owner]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the op and result registers are reset too, because their reset values are visible on the ALU and response ports.
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_control  <= '0;
            op_left     <= '0;
            op_right    <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_control <= req_control[win];
                op_left    <= req_left[win];
                op_right   <= req_right[win];
                owner      <= win;
                last_grant <= win;
            end
            // Zero flag is derived here rather than taken from the ALU.
            if (state == EXEC && !flush) begin
                resp_result <= alu_result;
                resp_zero   <= (alu_result == '0);
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters (index 0: execute-stage sequencer, index 1: auxiliary unit such as CSR/debug address calculation) with round-robin arbitration and valid/ready handshakes on both request and response sides. Latches the winning operation, drives the ALU ports for one cycle, captures the result and zero flag, and holds them until the owning requester accepts. One operation is in flight at a time.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the ALU.
- `NUM_REQ`, 2, number of requesters; fixed at 2, and other values are unsupported.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: abandons the in-flight op with no response.
- `req_valid` in [1:0]: request valid per requester.
- `req_ready` out [1:0]: request accepted when `req_valid[i] & req_ready[i]`.
- `req_control` in [1:0][3:0]: ALU opcode (`ALU_*` from `common`).
- `req_left` in [1:0][WIDTH-1:0]: left operand.
- `req_right` in [1:0][WIDTH-1:0]: right operand.
- `resp_valid` out [1:0]: result valid; at most one bit is set.
- `resp_ready` in [1:0]: response consumed when `resp_valid[i] & resp_ready[i]`.
- `resp_result` out [WIDTH-1:0]: captured ALU result, shared by both requesters.
- `resp_zero` out 1: 1 when captured result == 0.
- `alu_control` out [3:0]: to ALU `control`.
- `alu_left_operand` out [WIDTH-1:0]: to ALU `left_operand`.
- `alu_right_operand` out [WIDTH-1:0]: to ALU `right_operand`.
- `alu_result` in [WIDTH-1:0]: from ALU `result`.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational.
  - If only one `req_valid` bit is set, that requester wins.
  - If both are set, the requester != `last_grant` wins.
  - `req_ready[win]=1`; the other bit is 0.
  - On handshake: latch control/operands into the op registers, set `owner=win` and `last_grant=win`, go to EXEC.
- EXEC:
  - Op registers drive the `alu_*` outputs.
  - At the clock edge, capture `alu_result` into `resp_result` and compute `resp_zero = (alu_result==0)` locally; the ALU's ZeroFlag is not used.
  - Go to RESP.
- RESP:
  - `resp_valid[owner]=1`; `resp_result` and `resp_zero` are stable.
  - On `resp_ready[owner]`, go to IDLE.
  - `resp_ready` of the non-owner is ignored.
- `req_ready` is 0 in EXEC and RESP. A new request is not accepted in the same cycle as a response handshake; it is accepted in IDLE on the next cycle.
- `flush`:
  - In EXEC or RESP: go to IDLE next cycle, no response (`resp_valid` is never asserted for that op if flushed in EXEC); `last_grant` is kept.
  - In IDLE: suppresses acceptance (`req_ready=0`).
  - Flush takes priority over a simultaneous response handshake; the result is the same either way: IDLE.
- `alu_*` outputs hold the op registers in every state; they are only meaningful in EXEC.
- Opcodes are passed through unchecked. Unknown codes get whatever the ALU does (its default is ADD).

## Timing
- Reset values:
  - state=IDLE, `last_grant=1` (requester 0 wins the first tie), owner=0.
  - `resp_valid=0`, `resp_result=0`, `resp_zero=0`.
  - `alu_control=0`, `alu_left_operand=0`, `alu_right_operand=0`.
  - `req_ready=0` during the reset cycle.
- Latency: request handshake at edge N → EXEC during cycle N+1 → `resp_valid` high from cycle N+2.
- Minimum issue interval is 3 cycles per op (accept, exec, respond with `resp_ready` already high).
- `resp_valid` stays high, with result unchanged, until the handshake, flush or reset.
- Reset mid-operation (EXEC or RESP): all state returns to reset values next edge; the pending op is lost with no response.
- Requester inputs are only sampled at the IDLE handshake. Changes afterwards do not affect the in-flight op.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A requester waits at most one op.

## Test plan
- Req0 ADD 5+7, `resp_ready[0]=1` → accepted at edge N; `resp_valid=2'b01`, `resp_result=12`, `resp_zero=0` in cycle N+2; IDLE at N+3.
- Req1 SUB 9−9 alone → `resp_valid=2'b10`, `resp_result=0`, `resp_zero=1`; `req_ready[0]` stays 0 throughout.
- Both valid continuously after reset (req0 ADD 1+1, req1 SLT −1,0), responses always ready → grants 0,1,0,1; results 2, 1, 2, 1; each issue 3 cycles apart.
- Req0 SRA 0x80000000 by 4 with `resp_ready[0]` low for 3 cycles, `resp_ready[1]` high → `resp_result=0x80000000>>>4` per the ALU held stable (not just 0xF8000000 assumed), no new accept, `resp_ready[1]` ignored; completes on `resp_ready[0]`.
- `flush` asserted in EXEC → no `resp_valid`; IDLE next cycle; next tie is won by the non-flushed requester, per `last_grant`.
- `reset` asserted in RESP → next cycle `resp_valid=0`, `resp_result=0`; first subsequent tie is granted to requester 0.
